cheri_tag_wbuf: RTL and testbench



---
 rtl/cheri_tag_wbuf.sv | 100 ++++++++++
 tb/tb_cheri_tag_wbuf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cheri_tag_wbuf.sv
// cheri_tag_wbuf: coalescing CHERI tag write buffer with in-order drain,
// youngest-match load forwarding and a flush/drain handshake.
module cheri_tag_wbuf #(
  parameter int Depth     = 8,
  parameter int AddrWidth = 64,
  parameter int TagWidth  = 1,
  parameter int CapBytes  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [TagWidth-1:0]  wr_tag_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [TagWidth-1:0]  mem_tag_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_hit_o,
  output logic [TagWidth-1:0]  lkp_tag_o,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic                 empty_o
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(CapBytes);
  localparam int GW = AddrWidth - OW;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [GW-1:0]       gran_q [Depth];
  logic [TagWidth-1:0] tag_q  [Depth];
  logic [PW-1:0]       head, tail, hit_idx;
  logic [CW-1:0]       count;
  logic [1:0]          state;
  logic [GW-1:0]       wr_gran, lkp_gran;
  logic                hit, accept, push, pop;
  logic                unused_low;

  assign wr_gran    = wr_addr_i[AddrWidth-1:OW];
  assign lkp_gran   = lkp_addr_i[AddrWidth-1:OW];
  assign unused_low = ^{wr_addr_i & AddrWidth'(CapBytes - 1), lkp_addr_i & AddrWidth'(CapBytes - 1)};

  // Scan from head towards tail so the youngest lookup match is the last one kept.
  // The head (k == 0) is excluded from coalescing because it may leave this cycle.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    lkp_hit_o = 1'b0;
    lkp_tag_o = '0;
    for (int k = 0; k < Depth; k++) begin
      if (CW'(k) < count) begin
        if (k != 0 && wr_valid_i && gran_q[head + PW'(k)] == wr_gran) begin
          hit     = 1'b1;
          hit_idx = head + PW'(k);
        end
        if (gran_q[head + PW'(k)] == lkp_gran) begin
          lkp_hit_o = 1'b1;
          lkp_tag_o = tag_q[head + PW'(k)];
        end
      end
    end
  end

  assign wr_ready_o   = (state == IDLE) && (!count[PW] || hit);
  assign accept       = wr_valid_i && wr_ready_o;
  assign push         = accept && !hit;
  assign pop          = mem_valid_o && mem_ready_i;
  assign mem_valid_o  = count != '0;
  assign empty_o      = count == '0;
  assign mem_addr_o   = AddrWidth'(gran_q[head]) << OW;
  assign mem_tag_o    = tag_q[head];
  assign flush_done_o = state == DONE;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
      state <= state == IDLE  ? (flush_i ? DRAIN : IDLE) :
               state == DRAIN ? (count == '0 ? DONE : DRAIN) : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      gran_q[tail] <= wr_gran;
      tag_q[tail]  <= wr_tag_i;
    end
    if (accept && hit) tag_q[hit_idx] <= wr_tag_i;
  end
endmodule

// File: tb/tb_cheri_tag_wbuf.sv
// tb_cheri_tag_wbuf: scoreboard bench for the tag write buffer (Depth 8 and Depth 4 instances).
module tb_cheri_tag_wbuf;
  typedef struct packed {
    logic [59:0] g;
    logic        t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, wr_tag, mem_valid, mem_ready, mem_tag;
  logic        lkp_hit, lkp_tag, flush, flush_done, empty;
  logic [63:0] wr_addr, mem_addr, lkp_addr;
  logic        d4_valid, d4_ready, d4_tag, d4_mvalid, d4_mready, d4_mtag;
  logic        d4_lhit, d4_ltag, d4_flush, d4_done, d4_empty;
  logic [63:0] d4_addr, d4_maddr, d4_lkp;
  ent_t        sb[$];
  ent_t        q4[$];
  int          fsm_m;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  cheri_tag_wbuf #(.Depth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_tag_i(wr_tag), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_tag_o(mem_tag), .lkp_addr_i(lkp_addr), .lkp_hit_o(lkp_hit),
    .lkp_tag_o(lkp_tag), .flush_i(flush), .flush_done_o(flush_done), .empty_o(empty)
  );

  cheri_tag_wbuf #(.Depth(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(d4_valid), .wr_ready_o(d4_ready),
    .wr_addr_i(d4_addr), .wr_tag_i(d4_tag), .mem_valid_o(d4_mvalid), .mem_ready_i(d4_mready),
    .mem_addr_o(d4_maddr), .mem_tag_o(d4_mtag), .lkp_addr_i(d4_lkp), .lkp_hit_o(d4_lhit),
    .lkp_tag_o(d4_ltag), .flush_i(d4_flush), .flush_done_o(d4_done), .empty_o(d4_empty)
  );

  // One clock cycle on the Depth-8 instance: drive, compare against the scoreboard, advance it.
  task automatic cyc(input logic v, input logic [63:0] a, input logic t, input logic mr, input logic f);
    ent_t e;
    int   hit, n;
    logic rdy, lh, lt;
    wr_valid = v; wr_addr = a; wr_tag = t; mem_ready = mr; flush = f;
    #1;
    n = sb.size();
    checks++;
    if (empty !== (n == 0)) begin errors++; $display("FAIL empty got %b exp %b", empty, n == 0); end
    checks++;
    if (mem_valid !== (n != 0)) begin errors++; $display("FAIL mem_valid got %b exp %b", mem_valid, n != 0); end
    if (n != 0) begin
      checks++;
      if (mem_addr !== {sb[0].g, 4'h0} || mem_tag !== sb[0].t) begin
        errors++; $display("FAIL mem_head got %h/%b exp %h/%b", mem_addr, mem_tag, {sb[0].g, 4'h0}, sb[0].t);
      end
    end
    checks++;
    if (flush_done !== (fsm_m == 2)) begin errors++; $display("FAIL flush_done got %b exp %b", flush_done, fsm_m == 2); end
    lh = 1'b0; lt = 1'b0;
    foreach (sb[i]) if (sb[i].g == lkp_addr[63:4]) begin lh = 1'b1; lt = sb[i].t; end
    checks++;
    if (lkp_hit !== lh || lkp_tag !== lt) begin
      errors++; $display("FAIL lookup %h got %b/%b exp %b/%b", lkp_addr, lkp_hit, lkp_tag, lh, lt);
    end
    hit = -1;
    for (int i = 1; i < n; i++) if (v && sb[i].g == a[63:4]) hit = i;
    rdy = (fsm_m == 0) && (n < 8 || hit >= 0);
    checks++;
    if (wr_ready !== rdy) begin errors++; $display("FAIL wr_ready addr %h got %b exp %b", a, wr_ready, rdy); end
    fsm_m = fsm_m == 0 ? (f ? 1 : 0) : fsm_m == 1 ? (n == 0 ? 2 : 1) : 0;
    if (v && rdy) begin
      if (hit >= 0) sb[hit].t = t;
      else begin e.g = a[63:4]; e.t = t; sb.push_back(e); end
    end
    if (mr && n != 0) void'(sb.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    wr_valid = 0; flush = 0; mem_ready = 0; d4_valid = 0; d4_mready = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; sb.delete(); q4.delete(); fsm_m = 0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst wr_ready got %b exp 1", wr_ready); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst mem_valid got %b exp 0", mem_valid); end
    checks++; if (lkp_hit !== 1'b0 || lkp_tag !== 1'b0) begin errors++; $display("FAIL rst lookup got %b/%b exp 0/0", lkp_hit, lkp_tag); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rst flush_done got %b exp 0", flush_done); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst empty got %b exp 1", empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_order;
    cyc(1, 64'h1000, 1, 0, 0);
    cyc(1, 64'h1010, 0, 0, 0);
    cyc(1, 64'h1020, 1, 0, 0);
    cyc(0, 64'h0, 0, 0, 0);
    drain(4);
  endtask

  task automatic test_coalesce;
    cyc(1, 64'h2000, 0, 0, 0);
    cyc(1, 64'h3000, 0, 0, 0);
    cyc(1, 64'h3008, 1, 0, 0);
    cyc(1, 64'h2000, 1, 0, 0);
    drain(4);
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) cyc(1, 64'h8000 + 64'(i * 16), i[0], 0, 0);
    cyc(1, 64'h9000, 1, 0, 0);
    cyc(1, 64'h8030, 0, 0, 0);
    cyc(1, 64'h9000, 1, 1, 0);
    drain(9);
  endtask

  task automatic test_forward;
    cyc(1, 64'h4000, 1, 0, 0);
    lkp_addr = 64'h400F;
    cyc(0, 64'h0, 0, 0, 0);
    lkp_addr = 64'h5000;
    cyc(1, 64'h5000, 0, 0, 0);
    cyc(0, 64'h0, 0, 0, 0);
    lkp_addr = 64'h6000;
    cyc(0, 64'h0, 0, 0, 0);
    lkp_addr = 64'h4000;
    cyc(1, 64'h4000, 0, 0, 0);
    cyc(0, 64'h0, 0, 0, 0);
    drain(4);
    lkp_addr = 64'h0;
  endtask

  task automatic test_flush;
    cyc(1, 64'hA000, 1, 0, 0);
    cyc(1, 64'hA010, 0, 0, 0);
    cyc(1, 64'hA020, 1, 0, 0);
    cyc(1, 64'hA030, 1, 1, 1);
    cyc(1, 64'hA040, 1, 0, 0);
    cyc(1, 64'hA050, 1, 1, 1);
    cyc(1, 64'hA060, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 64'hA070, 0, 1, 0);
    cyc(0, 64'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 64'h0, 0, 0, 0);
  endtask

  task automatic test_reset_drain;
    lkp_addr = 64'hB000;
    cyc(1, 64'hB000, 1, 0, 0);
    cyc(1, 64'hB010, 0, 0, 0);
    cyc(0, 64'h0, 0, 0, 1);
    cyc(0, 64'h0, 0, 0, 0);
    test_reset;
    for (int i = 0; i < 3; i++) cyc(0, 64'h0, 0, 0, 0);
    lkp_addr = 64'h0;
  endtask

  task automatic test_back_to_back;
    ent_t e;
    d4_flush = 0; d4_lkp = 64'h0;
    for (int i = 0; i < 26; i++) begin
      d4_valid  = i < 23;
      d4_addr   = 64'hC000 + 64'(i * 16);
      d4_tag    = 1'($urandom);
      d4_mready = i >= 3;
      #1;
      if (d4_valid) begin
        checks++;
        if (d4_ready !== 1'b1) begin errors++; $display("FAIL d4 wr_ready step %0d got %b exp 1", i, d4_ready); end
      end
      if (d4_mready) begin
        checks++;
        if (d4_mvalid !== 1'b1 || d4_maddr !== {q4[0].g, 4'h0} || d4_mtag !== q4[0].t) begin
          errors++; $display("FAIL d4 head step %0d got %b %h/%b exp 1 %h/%b", i, d4_mvalid, d4_maddr, d4_mtag, {q4[0].g, 4'h0}, q4[0].t);
        end
        void'(q4.pop_front());
      end
      if (d4_valid) begin e.g = d4_addr[63:4]; e.t = d4_tag; q4.push_back(e); end
      @(posedge clk); #1;
    end
    d4_valid = 0; d4_mready = 0;
    #1;
    checks++;
    if (d4_empty !== 1'b1 || d4_mvalid !== 1'b0) begin errors++; $display("FAIL d4 final empty got %b/%b exp 1/0", d4_empty, d4_mvalid); end
  endtask

  initial begin
    wr_valid = 0; wr_addr = 0; wr_tag = 0; mem_ready = 0; flush = 0; lkp_addr = 0;
    d4_valid = 0; d4_addr = 0; d4_tag = 0; d4_mready = 0; d4_flush = 0; d4_lkp = 0;
    rst_n = 1'b0; fsm_m = 0;
    @(posedge clk); #1;
    test_reset;
    test_order;
    test_coalesce;
    test_full;
    test_forward;
    test_flush;
    test_reset_drain;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
